// File: rtl/jcnt_pkg.sv
// Shared types and helpers for the Johnson-counter sequencer.
// Functions work on a 16-bit view of the ring, which is the widest supported.
package jcnt_pkg;

    typedef logic [1:0] jcnt_state_t;

    localparam jcnt_state_t ST_IDLE  = 2'd0;
    localparam jcnt_state_t ST_RUN   = 2'd1;
    localparam jcnt_state_t ST_PAUSE = 2'd2;
    localparam jcnt_state_t ST_DONE  = 2'd3;

    localparam int unsigned JCNT_MAX_W = 16;

    // Ones-count for the filling half, 2*w minus ones-count for the draining half.
    function automatic logic [5:0] jcnt_idx(input logic [15:0] ph, input int unsigned w);
        int unsigned pc;
        pc = 0;
        for (int unsigned i = 0; i < JCNT_MAX_W; i++) begin
            pc = pc + 32'(ph[i]);
        end
        if (ph[0] || (ph == 16'd0)) begin
            return 6'(pc);
        end
        return 6'((2 * w) - pc);
    endfunction

    // A legal Johnson state has at most one boundary between adjacent stages.
    function automatic logic jcnt_legal(input logic [15:0] ph, input int unsigned w);
        int unsigned edges;
        edges = 0;
        for (int unsigned i = 1; i < JCNT_MAX_W; i++) begin
            if ((i < w) && (ph[i] != ph[i-1])) begin
                edges = edges + 1;
            end
        end
        return (edges <= 1);
    endfunction

endpackage

// File: rtl/jcnt_ring.sv
// WIDTH-stage Johnson (twisted-ring) register with enable and synchronous clear.
module jcnt_ring #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] phase
);

    logic [WIDTH-1:0] phase_q;

    // Clear wins over advance so an abort always lands on the all-zeros state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_q <= '0;
        end else if (clr) begin
            phase_q <= '0;
        end else if (en) begin
            phase_q <= {phase_q[WIDTH-2:0], ~phase_q[WIDTH-1]};
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/jcnt_seq_ctrl.sv
// Run/pause/abort sequencer around a Johnson ring used as a multi-phase strobe source.
// Optional illegal-state recovery and sticky err flag: define JCNT_SELF_CORRECT_EN.
module jcnt_seq_ctrl
    import jcnt_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CYC_W = 8
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic [CYC_W-1:0]              cycles,
    input  logic                          hold,
    input  logic                          stop,
    output logic [WIDTH-1:0]              phase,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic                          wrap,
    output logic                          busy,
    output logic                          paused,
    output logic                          done,
    output logic                          err
);

    localparam int unsigned IDX_W = $clog2(2 * WIDTH);
    localparam logic [WIDTH-1:0] LAST_PH = {1'b1, {(WIDTH-1){1'b0}}};

    jcnt_state_t      state_q, state_d;
    logic [CYC_W-1:0] remaining_q, remaining_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             paused_q, paused_d;
    logic             err_q, err_d;
    logic             ring_en, ring_clr;

    jcnt_ring #(.WIDTH(WIDTH)) u_ring (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (ring_en),
        .clr   (ring_clr),
        .phase (phase)
    );

    assign phase_idx = IDX_W'(jcnt_idx(16'(phase), WIDTH));

    // State and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            paused_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            paused_q    <= paused_d;
            err_q       <= err_d;
        end
    end

    // Next state, ring control and next output values.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ring_en     = 1'b0;
        ring_clr    = 1'b0;
        wrap_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start && (cycles != '0)) begin
                    state_d     = ST_RUN;
                    remaining_d = cycles;
                    ring_clr    = 1'b1;
                    err_d       = 1'b0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    ring_clr = 1'b1;
                end else if (hold) begin
                    state_d = ST_PAUSE;
                end else begin
                    ring_en = 1'b1;
                    // Last state of a rotation: the advance lands on all-zeros.
                    if (phase == LAST_PH) begin
                        wrap_d      = 1'b1;
                        remaining_d = remaining_q - CYC_W'(1);
                        if (remaining_q == CYC_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d  = ST_IDLE;
                    ring_clr = 1'b1;
                end else if (!hold) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                ring_clr = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                ring_clr = 1'b1;
            end
        endcase

`ifdef JCNT_SELF_CORRECT_EN
        // Recovery from a corrupted ring overrides everything else this cycle.
        if (!jcnt_legal(16'(phase), WIDTH)) begin
            state_d     = state_q;
            remaining_d = remaining_q;
            ring_en     = 1'b0;
            ring_clr    = 1'b1;
            wrap_d      = 1'b0;
            err_d       = 1'b1;
        end
`else
        err_d = 1'b0;
`endif

        busy_d   = (state_d == ST_RUN) || (state_d == ST_PAUSE);
        paused_d = (state_d == ST_PAUSE);
        done_d   = (state_d == ST_DONE);
    end

    assign wrap   = wrap_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign paused = paused_q;
    assign err    = err_q;

endmodule

// File: tb/tb_jcnt_seq_ctrl.sv
// Self-checking bench for jcnt_seq_ctrl against a step-index reference model.
module tb_jcnt_seq_ctrl;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk;
    logic          n_rst;
    logic          start;
    logic [CW-1:0] cycles;
    logic          hold;
    logic          stop;
    logic [W-1:0]  phase;
    logic [2:0]    phase_idx;
    logic          wrap, busy, paused, done, err;

    jcnt_seq_ctrl #(.WIDTH(W), .CYC_W(CW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .cycles    (cycles),
        .hold      (hold),
        .stop      (stop),
        .phase     (phase),
        .phase_idx (phase_idx),
        .wrap      (wrap),
        .busy      (busy),
        .paused    (paused),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 run, 2 pause, 3 done; step = position in rotation.
    int m_mode = 0;
    int m_step = 0;
    int m_rot  = 0;
    bit m_wrap = 0;
    bit m_err  = 0;
    bit m_illegal = 0;

    // Observation tallies for directed checks.
    int cyc = 0;
    int n_wrap = 0, n_done = 0, n_win = 0, n_dw = 0;
    int last_wrap_t = 0, wrap_gap = 0;
    int done_t = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ph_of(input int s);
        if (s <= W) return W'((1 << s) - 1);
        return W'(((1 << W) - 1) & ~((1 << (s - W)) - 1));
    endfunction

    task automatic model_edge(input bit st, input int cy, input bit hd, input bit sp);
        m_wrap = 0;
        if (m_illegal) begin
            m_step = 0;
            m_err = 1;
            m_illegal = 0;
        end else begin
            case (m_mode)
                0: if (st && cy != 0) begin m_mode = 1; m_rot = cy; m_step = 0; m_err = 0; end
                1: begin
                    if (sp) begin m_mode = 0; m_step = 0; end
                    else if (hd) m_mode = 2;
                    else begin
                        m_step = (m_step + 1) % (2 * W);
                        if (m_step == 0) begin
                            m_wrap = 1;
                            m_rot--;
                            if (m_rot == 0) m_mode = 3;
                        end
                    end
                end
                2: begin
                    if (sp) begin m_mode = 0; m_step = 0; end
                    else if (!hd) m_mode = 1;
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic tick();
        bit st, hd, sp;
        int cy;
        st = start; hd = hold; sp = stop; cy = int'(cycles);
        @(posedge clk);
        model_edge(st, cy, hd, sp);
        #1;
        chk("phase", 32'(phase), 32'(ph_of(m_step)));
        chk("phase_idx", 32'(phase_idx), 32'(m_step));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("done", 32'(done), 32'(m_mode == 3));
        chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
        chk("paused", 32'(paused), 32'(m_mode == 2));
        chk("err", 32'(err), 32'(m_err));
        cyc++;
        if (wrap) begin
            n_wrap++;
            wrap_gap = cyc - last_wrap_t;
            last_wrap_t = cyc;
        end
        if (done) begin n_done++; done_t = cyc; end
        if (done && wrap) n_dw++;
        if (busy || done) n_win++;
    endtask

    task automatic clear_tally();
        cyc = 0; n_wrap = 0; n_done = 0; n_win = 0; n_dw = 0;
        last_wrap_t = 0; wrap_gap = 0; done_t = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin tick(); k++; end
        if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic wait_phase(input string tag, input logic [W-1:0] target, input int budget);
        int k;
        k = 0;
        while (phase !== target && k < budget) begin tick(); k++; end
        if (phase !== target) chk({tag, "_timeout"}, 32'(phase), 32'(target));
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; cycles = '0; hold = 1'b0; stop = 1'b0;
        #3;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        tick();

        // Two rotations with no hold; then a start presented while in DONE.
        clear_tally();
        start = 1'b1; cycles = 8'd2;
        tick();
        start = 1'b0;
        wait_done("run2", 40);
        chk("run2_wraps", 32'(n_wrap), 32'd2);
        chk("run2_wrap_gap", 32'(wrap_gap), 32'(2 * W));
        chk("run2_done_cnt", 32'(n_done), 32'd1);
        chk("run2_done_with_wrap", 32'(n_dw), 32'd1);
        chk("run2_window", 32'(n_win), 32'(2 * W * 2 + 1));
        start = 1'b1; cycles = 8'd2;
        tick();
        start = 1'b0;
        tick();
        chk("done_start_ignored", 32'(busy), 32'd0);

        // Zero rotation count is ignored.
        start = 1'b1; cycles = 8'd0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_phase", 32'(phase), 32'd0);

        // Three rotations with a hold while the ring sits at 0111.
        clear_tally();
        start = 1'b1; cycles = 8'd3;
        tick();
        start = 1'b0;
        wait_phase("hold3", 4'b0111, 20);
        hold = 1'b1;
        repeat (4) tick();
        chk("hold_frozen", 32'(phase), 32'h7);
        chk("hold_paused", 32'(paused), 32'd1);
        hold = 1'b0;
        wait_done("hold3", 60);
        chk("hold3_wraps", 32'(n_wrap), 32'd3);
        chk("hold3_done_t", 32'(done_t), 32'(2 * W * 3 + 1 + 5));
        tick();

        // Stop together with hold at 1110 aborts without done or wrap.
        start = 1'b1; cycles = 8'd2;
        tick();
        start = 1'b0;
        wait_phase("stop", 4'b1110, 20);
        stop = 1'b1; hold = 1'b1;
        tick();
        stop = 1'b0; hold = 1'b0;
        chk("stop_phase", 32'(phase), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        chk("stop_wrap", 32'(wrap), 32'd0);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            start  = ($urandom % 4) == 0;
            cycles = CW'($urandom_range(0, 2));
            hold   = ($urandom % 8) == 0;
            stop   = ($urandom % 32) == 0;
            tick();
        end
        start = 1'b0; hold = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

`ifdef JCNT_SELF_CORRECT_EN
        // Corrupt the ring mid-run; it must recover and still finish.
        start = 1'b1; cycles = 8'd1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        force dut.u_ring.phase_q = 4'b0101;
        #1 release dut.u_ring.phase_q;
        m_illegal = 1;
        tick();
        chk("sc_phase", 32'(phase), 32'd0);
        chk("sc_err", 32'(err), 32'd1);
        chk("sc_busy", 32'(busy), 32'd1);
        wait_done("sc", 30);
        tick();
        chk("sc_err_sticky", 32'(err), 32'd1);
        start = 1'b1; cycles = 8'd1;
        tick();
        start = 1'b0;
        chk("sc_err_cleared", 32'(err), 32'd0);
        wait_done("sc2", 30);
        tick();
`else
        chk("err_tied", 32'(err), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
